// File: rtl/bus_arbiter_n.sv
// N-master to single-slave arbiter for the femto pulse-request bus.
// Fixed-priority or round-robin grant, response routing, optional timeout.
module bus_arbiter_n #(
    parameter int    NUM_MASTERS = 2,
    parameter int    XLEN        = 32,
    parameter int    BUS_WIDTH   = 32,
    parameter int    ACC_W       = 2,
    parameter string ARB_MODE    = "RR",
    parameter int    TIMEOUT     = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_MASTERS*XLEN-1:0]      m_addr,
    input  logic [NUM_MASTERS-1:0]           m_w_rb,
    input  logic [NUM_MASTERS*ACC_W-1:0]     m_acc,
    input  logic [NUM_MASTERS*BUS_WIDTH-1:0] m_wdata,
    input  logic [NUM_MASTERS-1:0]           m_req,
    output logic [NUM_MASTERS-1:0]           m_resp,
    output logic [BUS_WIDTH-1:0]             m_rdata,
    output logic [NUM_MASTERS-1:0]           m_fault,
    output logic [NUM_MASTERS-1:0]           m_tmo,
    output logic [XLEN-1:0]                  addr,
    output logic                             w_rb,
    output logic [ACC_W-1:0]                 acc,
    output logic [BUS_WIDTH-1:0]             wdata,
    output logic                             req,
    input  logic                             resp,
    input  logic [BUS_WIDTH-1:0]             rdata,
    input  logic                             fault
);

    localparam int  IW    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int  CW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit  FIXED = (ARB_MODE == "FIXED");

    typedef enum logic {IDLE, BUSY} state_e;

    state_e                     state_q, state_d;
    logic [NUM_MASTERS-1:0]     pend_q, pend_d;
    logic [IW-1:0]              owner_q, ptr_q;
    logic [CW-1:0]              cnt_q;

    logic [XLEN-1:0]            p_addr_q  [NUM_MASTERS];
    logic                       p_w_q     [NUM_MASTERS];
    logic [ACC_W-1:0]           p_acc_q   [NUM_MASTERS];
    logic [BUS_WIDTH-1:0]       p_wd_q    [NUM_MASTERS];

    logic [XLEN-1:0]            in_addr   [NUM_MASTERS];
    logic [ACC_W-1:0]           in_acc    [NUM_MASTERS];
    logic [BUS_WIDTH-1:0]       in_wd     [NUM_MASTERS];

    logic [XLEN-1:0]            cur_addr_q, g_addr;
    logic                       cur_w_q, g_w;
    logic [ACC_W-1:0]           cur_acc_q, g_acc;
    logic [BUS_WIDTH-1:0]       cur_wd_q, g_wd;

    logic [NUM_MASTERS-1:0]     inflight, req_ok, cand;
    logic [IW-1:0]              gnt;
    logic                       issue, tmo_hit, busy;
    int                         idx;

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_m
        assign in_addr[m] = m_addr[m*XLEN +: XLEN];
        assign in_acc[m]  = m_acc[m*ACC_W +: ACC_W];
        assign in_wd[m]   = m_wdata[m*BUS_WIDTH +: BUS_WIDTH];

        always_ff @(posedge clk) begin
            if (req_ok[m]) begin
                p_addr_q[m] <= in_addr[m];
                p_w_q[m]    <= m_w_rb[m];
                p_acc_q[m]  <= in_acc[m];
                p_wd_q[m]   <= in_wd[m];
            end
        end
    end

    always_comb begin
        busy     = (state_q == BUSY);
        tmo_hit  = (TIMEOUT > 0) && busy && !resp
                   && (int'(cnt_q) == TIMEOUT - 1);
        // The owner may re-request once its access completes.
        inflight = '0;
        if (busy && !resp && !tmo_hit) inflight[owner_q] = 1'b1;
        req_ok   = m_req & ~pend_q & ~inflight;
        cand     = pend_q | req_ok;

        // Descending scan: the last hit is the highest-priority candidate.
        gnt = '0;
        idx = 0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (FIXED) begin
                idx = i;
            end else begin
                idx = int'(ptr_q) + 1 + i;
                if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            end
            if (cand[IW'(idx)]) gnt = IW'(idx);
        end

        issue  = (|cand) && (!busy || resp);
        g_addr = req_ok[gnt] ? in_addr[gnt]  : p_addr_q[gnt];
        g_w    = req_ok[gnt] ? m_w_rb[gnt]   : p_w_q[gnt];
        g_acc  = req_ok[gnt] ? in_acc[gnt]   : p_acc_q[gnt];
        g_wd   = req_ok[gnt] ? in_wd[gnt]    : p_wd_q[gnt];

        req    = issue;
        addr   = issue ? g_addr : cur_addr_q;
        w_rb   = issue ? g_w    : cur_w_q;
        acc    = issue ? g_acc  : cur_acc_q;
        wdata  = issue ? g_wd   : cur_wd_q;

        m_fault = '0;
        if (issue) m_fault[gnt] = fault;
        m_resp  = '0;
        m_tmo   = '0;
        m_rdata = '0;
        if (busy && (resp || tmo_hit)) m_resp[owner_q] = 1'b1;
        if (tmo_hit) m_tmo[owner_q] = 1'b1;
        if (busy && resp) m_rdata = rdata;

        pend_d = pend_q | req_ok;
        if (issue) pend_d[gnt] = 1'b0;

        state_d = state_q;
        if (issue) state_d = BUSY;
        else if (busy && (resp || tmo_hit)) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            owner_q <= '0;
            ptr_q   <= IW'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (issue) begin
                owner_q <= gnt;
                ptr_q   <= gnt;
                cnt_q   <= '0;
            end else if (busy) begin
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            cur_addr_q <= g_addr;
            cur_w_q    <= g_w;
            cur_acc_q  <= g_acc;
            cur_wd_q   <= g_wd;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed bench for bus_arbiter_n: RR instance with timeout,
// FIXED instance without.
module tb_bus_arbiter_n;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int BW = 32;
    localparam int AW = 2;

    logic            clk, rst;
    logic [N*XL-1:0] m_addr;
    logic [N-1:0]    m_w_rb;
    logic [N*AW-1:0] m_acc;
    logic [N*BW-1:0] m_wdata;
    logic [N-1:0]    m_req;
    logic            resp, fault;
    logic [BW-1:0]   rdata;

    logic [N-1:0]    m_resp, m_fault, m_tmo;
    logic [BW-1:0]   m_rdata, wdata;
    logic [XL-1:0]   addr;
    logic            w_rb, req;
    logic [AW-1:0]   acc;

    logic [N-1:0]    f_resp, f_fault, f_tmo;
    logic [BW-1:0]   f_rdata, f_wdata;
    logic [XL-1:0]   f_addr;
    logic            f_w_rb, f_req;
    logic [AW-1:0]   f_acc;

    int errors = 0;
    int checks = 0;

    bus_arbiter_n #(
        .NUM_MASTERS(N), .XLEN(XL), .BUS_WIDTH(BW), .ACC_W(AW),
        .ARB_MODE("RR"), .TIMEOUT(8)
    ) u_rr (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_w_rb(m_w_rb), .m_acc(m_acc),
        .m_wdata(m_wdata), .m_req(m_req),
        .m_resp(m_resp), .m_rdata(m_rdata),
        .m_fault(m_fault), .m_tmo(m_tmo),
        .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
        .req(req), .resp(resp), .rdata(rdata), .fault(fault)
    );

    bus_arbiter_n #(
        .NUM_MASTERS(N), .XLEN(XL), .BUS_WIDTH(BW), .ACC_W(AW),
        .ARB_MODE("FIXED"), .TIMEOUT(0)
    ) u_fix (
        .clk(clk), .rst(rst),
        .m_addr(m_addr), .m_w_rb(m_w_rb), .m_acc(m_acc),
        .m_wdata(m_wdata), .m_req(m_req),
        .m_resp(f_resp), .m_rdata(f_rdata),
        .m_fault(f_fault), .m_tmo(f_tmo),
        .addr(f_addr), .w_rb(f_w_rb), .acc(f_acc), .wdata(f_wdata),
        .req(f_req), .resp(resp), .rdata(rdata), .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic put(input int m, input logic [31:0] a,
                       input logic w, input logic [31:0] d);
        m_addr[m*XL +: XL]  = a;
        m_w_rb[m]           = w;
        m_acc[m*AW +: AW]   = 2'd2;
        m_wdata[m*BW +: BW] = d;
        m_req[m]            = 1'b1;
    endtask

    task automatic next();
        @(negedge clk);
        m_req = '0;
        resp  = 1'b0;
        fault = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req); end
        checks++; if (m_resp !== 4'b0) begin errors++; $display("FAIL rst_resp: got %b want 0000", m_resp); end
        checks++; if (m_fault !== 4'b0) begin errors++; $display("FAIL rst_fault: got %b want 0000", m_fault); end
        checks++; if (m_tmo !== 4'b0) begin errors++; $display("FAIL rst_tmo: got %b want 0000", m_tmo); end
        checks++; if (f_req !== 1'b0) begin errors++; $display("FAIL rst_freq: got %b want 0", f_req); end
        next();
        resp = 1'b1;
        rdata = 32'h1111_2222;
        #1;
        checks++; if (m_resp !== 4'b0) begin errors++; $display("FAIL rst_stray: got %b want 0000", m_resp); end
        next();
    endtask

    task automatic test_single();
        do_reset();
        put(2, 32'h100, 1'b0, 32'h0);
        #1;
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", req); end
        checks++; if (addr !== 32'h100) begin errors++; $display("FAIL single_addr: got %h want 00000100", addr); end
        checks++; if (w_rb !== 1'b0) begin errors++; $display("FAIL single_wrb: got %b want 0", w_rb); end
        next();
        next();
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL single_hold_req: got %b want 0", req); end
        checks++; if (addr !== 32'h100) begin errors++; $display("FAIL single_hold_addr: got %h want 00000100", addr); end
        next();
        resp = 1'b1;
        rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (m_resp !== 4'b0100) begin errors++; $display("FAIL single_resp: got %b want 0100", m_resp); end
        checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", m_rdata); end
        next();
        #1;
        checks++; if (m_resp !== 4'b0) begin errors++; $display("FAIL single_after: got %b want 0000", m_resp); end
    endtask

    task automatic test_fault();
        do_reset();
        put(1, 32'h200, 1'b1, 32'h55);
        fault = 1'b1;
        #1;
        checks++; if (m_fault !== 4'b0010) begin errors++; $display("FAIL fault_bit: got %b want 0010", m_fault); end
        checks++; if (w_rb !== 1'b1) begin errors++; $display("FAIL fault_wrb: got %b want 1", w_rb); end
        checks++; if (wdata !== 32'h55) begin errors++; $display("FAIL fault_wdata: got %h want 00000055", wdata); end
        next();
        fault = 1'b1;
        #1;
        checks++; if (m_fault !== 4'b0) begin errors++; $display("FAIL fault_once: got %b want 0000", m_fault); end
        next();
        resp = 1'b1;
        #1;
        checks++; if (m_resp !== 4'b0010) begin errors++; $display("FAIL fault_resp: got %b want 0010", m_resp); end
        next();
    endtask

    task automatic test_rr();
        do_reset();
        put(0, 32'h1000, 1'b0, 32'h0);
        put(1, 32'h1100, 1'b0, 32'h0);
        put(3, 32'h1300, 1'b0, 32'h0);
        #1;
        checks++; if (addr !== 32'h1000) begin errors++; $display("FAIL rr_g0: got %h want 00001000", addr); end
        next();
        resp = 1'b1;
        #1;
        checks++; if (m_resp !== 4'b0001) begin errors++; $display("FAIL rr_r0: got %b want 0001", m_resp); end
        checks++; if (req !== 1'b1 || addr !== 32'h1100) begin errors++; $display("FAIL rr_g1: got req=%b addr=%h want 1 00001100", req, addr); end
        next();
        resp = 1'b1;
        #1;
        checks++; if (m_resp !== 4'b0010) begin errors++; $display("FAIL rr_r1: got %b want 0010", m_resp); end
        checks++; if (req !== 1'b1 || addr !== 32'h1300) begin errors++; $display("FAIL rr_g3: got req=%b addr=%h want 1 00001300", req, addr); end
        next();
        resp = 1'b1;
        #1;
        checks++; if (m_resp !== 4'b1000) begin errors++; $display("FAIL rr_r3: got %b want 1000", m_resp); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rr_end: got %b want 0", req); end
        next();
    endtask

    task automatic test_fixed();
        do_reset();
        put(0, 32'h2000, 1'b0, 32'h0);
        put(3, 32'h2300, 1'b0, 32'h0);
        #1;
        checks++; if (f_addr !== 32'h2000) begin errors++; $display("FAIL fix_g0: got %h want 00002000", f_addr); end
        next();
        for (int k = 1; k <= 2; k++) begin
            resp = 1'b1;
            put(0, 32'h2000 + 32'(4 * k), 1'b0, 32'h0);
            #1;
            checks++; if (f_resp !== 4'b0001) begin errors++; $display("FAIL fix_r%0d: got %b want 0001", k, f_resp); end
            checks++; if (f_addr !== 32'h2000 + 32'(4 * k)) begin errors++; $display("FAIL fix_starve%0d: got %h want %h", k, f_addr, 32'h2000 + 32'(4 * k)); end
            next();
        end
        resp = 1'b1;
        #1;
        checks++; if (f_req !== 1'b1 || f_addr !== 32'h2300) begin errors++; $display("FAIL fix_g3: got req=%b addr=%h want 1 00002300", f_req, f_addr); end
        next();
        resp = 1'b1;
        #1;
        checks++; if (f_resp !== 4'b1000 || f_req !== 1'b0) begin errors++; $display("FAIL fix_r3: got resp=%b req=%b want 1000 0", f_resp, f_req); end
        next();
    endtask

    task automatic test_timeout();
        do_reset();
        rdata = 32'h1234_5678;
        put(0, 32'h3000, 1'b0, 32'h0);
        put(2, 32'h3200, 1'b0, 32'h0);
        #1;
        checks++; if (addr !== 32'h3000) begin errors++; $display("FAIL tmo_g0: got %h want 00003000", addr); end
        next();
        for (int k = 1; k <= 7; k++) begin
            #1;
            checks++; if (m_resp !== 4'b0 || req !== 1'b0) begin errors++; $display("FAIL tmo_wait%0d: got resp=%b req=%b want 0000 0", k, m_resp, req); end
            next();
        end
        #1;
        checks++; if (m_resp !== 4'b0001) begin errors++; $display("FAIL tmo_resp: got %b want 0001", m_resp); end
        checks++; if (m_tmo !== 4'b0001) begin errors++; $display("FAIL tmo_flag: got %b want 0001", m_tmo); end
        checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata: got %h want 00000000", m_rdata); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL tmo_nogrant: got %b want 0", req); end
        next();
        resp = 1'b1;
        #1;
        checks++; if (m_resp !== 4'b0) begin errors++; $display("FAIL tmo_stray: got %b want 0000", m_resp); end
        checks++; if (req !== 1'b1 || addr !== 32'h3200) begin errors++; $display("FAIL tmo_g2: got req=%b addr=%h want 1 00003200", req, addr); end
        next();
        resp = 1'b1;
        rdata = 32'h0000_CAFE;
        #1;
        checks++; if (m_resp !== 4'b0100 || m_tmo !== 4'b0) begin errors++; $display("FAIL tmo_r2: got resp=%b tmo=%b want 0100 0000", m_resp, m_tmo); end
        checks++; if (m_rdata !== 32'h0000_CAFE) begin errors++; $display("FAIL tmo_rd2: got %h want 0000cafe", m_rdata); end
        next();
    endtask

    task automatic test_reset_mid();
        do_reset();
        put(0, 32'h4000, 1'b0, 32'h0);
        put(1, 32'h4100, 1'b0, 32'h0);
        put(2, 32'h4200, 1'b0, 32'h0);
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        resp = 1'b1;
        #1;
        checks++; if (m_resp !== 4'b0) begin errors++; $display("FAIL rmid_resp: got %b want 0000", m_resp); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b want 0", req); end
        next();
        #1;
        checks++; if (req !== 1'b0 || f_req !== 1'b0) begin errors++; $display("FAIL rmid_idle: got req=%b freq=%b want 0 0", req, f_req); end
        next();
    endtask

    task automatic test_violation();
        do_reset();
        put(0, 32'h400, 1'b0, 32'h0);
        #1;
        checks++; if (addr !== 32'h400) begin errors++; $display("FAIL viol_g: got %h want 00000400", addr); end
        next();
        put(0, 32'h500, 1'b0, 32'h0);
        #1;
        checks++; if (req !== 1'b0 || addr !== 32'h400) begin errors++; $display("FAIL viol_drop: got req=%b addr=%h want 0 00000400", req, addr); end
        next();
        next();
        resp = 1'b1;
        #1;
        checks++; if (m_resp !== 4'b0001) begin errors++; $display("FAIL viol_resp: got %b want 0001", m_resp); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL viol_noreissue: got %b want 0", req); end
        next();
        #1;
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL viol_idle: got %b want 0", req); end
    endtask

    initial begin
        rst     = 1'b1;
        m_addr  = '0;
        m_w_rb  = '0;
        m_acc   = '0;
        m_wdata = '0;
        m_req   = '0;
        resp    = 1'b0;
        fault   = 1'b0;
        rdata   = '0;
        test_reset();
        test_single();
        test_fault();
        test_rr();
        test_fixed();
        test_timeout();
        test_reset_mid();
        test_violation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
